// File: rtl/sync_fifo_pkg.sv
// ----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared constants and types for the single-clock FIFO.
//   DEF_DATA_WIDTH : default word width of the FIFO data path.
//   DEF_DEPTH      : default number of storage words (power of two, >= 4).
//   ADDR_WIDTH     : pointer width for the default depth.
//   data_t         : one FIFO word at the default width.
//   ptr_inc()      : pointer increment helper; wraps DEPTH-1 -> 0 naturally.
// ----------------------------------------------------------------------------
package sync_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 16;
    localparam int ADDR_WIDTH     = $clog2(DEF_DEPTH);

    typedef logic [DEF_DATA_WIDTH-1:0] data_t;

    // Increment a default-width pointer. DEPTH is a power of two, so the
    // carry out of the top bit is simply dropped to wrap back to zero.
    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] ptr);
        return ptr + ADDR_WIDTH'(1);
    endfunction

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_if.sv
// ----------------------------------------------------------------------------
// sync_fifo_if
// Handshake/data bundle between a FIFO user and the FIFO itself.
//   wr_en, rd_en, din         : requests and write data from the user.
//   wr_ack, wr_err            : one-cycle status of the previous write request.
//   rd_ack, rd_err            : one-cycle status of the previous read request.
//   dout                      : registered read data, held between reads.
//   full, empty,
//   almost_full, almost_empty : occupancy flags.
// Modports:
//   master : the producer/consumer side (drives requests, observes status).
//   slave  : the FIFO side (observes requests, drives status and data).
// ----------------------------------------------------------------------------
interface sync_fifo_if
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] din;

    logic                  wr_ack;
    logic                  wr_err;
    logic                  rd_ack;
    logic                  rd_err;
    logic [DATA_WIDTH-1:0] dout;

    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;

    modport master (
        output wr_en,
        output rd_en,
        output din,
        input  wr_ack,
        input  wr_err,
        input  rd_ack,
        input  rd_err,
        input  dout,
        input  full,
        input  empty,
        input  almost_full,
        input  almost_empty
    );

    modport slave (
        input  wr_en,
        input  rd_en,
        input  din,
        output wr_ack,
        output wr_err,
        output rd_ack,
        output rd_err,
        output dout,
        output full,
        output empty,
        output almost_full,
        output almost_empty
    );

endinterface : sync_fifo_if

// File: rtl/sync_fifo_ram.sv
// ----------------------------------------------------------------------------
// sync_fifo_ram
// DEPTH x DATA_WIDTH storage with one write port and one registered read
// port. The read register has a read enable and a synchronous clear so the
// FIFO output reads as zero after reset and holds between accepted reads.
// The storage array itself is never cleared.
//   clk   : clock, all activity on the rising edge.
//   srst  : synchronous active-high clear of the read data register only.
//   we    : write enable; wdata stored at waddr.
//   waddr : write address.
//   wdata : write data.
//   re    : read enable; rdata loads mem[raddr] on the next edge.
//   raddr : read address.
//   rdata : registered read data.
// ----------------------------------------------------------------------------
module sync_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Write port. No reset: contents are logically discarded by the pointer
    // reset in the parent, so clearing the array is unnecessary.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Registered read port. The parent never reads and writes the same
    // address in one cycle (a read needs the FIFO non-empty, a write to the
    // read slot would need it full), so no read-during-write policy matters.
    always_ff @(posedge clk) begin
        if (srst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule : sync_fifo_ram

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with per-request ack/err status and occupancy flags.
// Pointers, the occupancy count, the flag decode and the status registers
// live here; storage and the registered read data are in sync_fifo_ram.
//   clk   : sole clock, everything updates on the rising edge.
//   clear : synchronous active-high reset; overrides every request.
//   fifo  : sync_fifo_if slave port (requests in, status/data/flags out).
// Behaviour summary:
//   - A write is accepted iff wr_en and not full; a read iff rd_en and not
//     empty, both judged on the flags as they stand before the edge.
//   - ack/err appear the cycle after the request; a cycle with no request
//     leaves both low.
//   - Flags decode from the count register, so they show post-edge state.
// ----------------------------------------------------------------------------
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic      clk,
    input  logic      clear,
    sync_fifo_if.slave fifo
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             wr_ack_q, wr_ack_d;
    logic             wr_err_q, wr_err_d;
    logic             rd_ack_q, rd_ack_d;
    logic             rd_err_q, rd_err_d;

    logic             wr_accept;
    logic             rd_accept;
    logic             full_flag;
    logic             empty_flag;

    // ------------------------------------------------------------------
    // Flag decode from the registered count
    // ------------------------------------------------------------------
    assign full_flag  = (count_q == CNT_FULL);
    assign empty_flag = (count_q == CNT_ZERO);

    assign fifo.full         = full_flag;
    assign fifo.empty        = empty_flag;
    assign fifo.almost_full  = (count_q == CNT_AFULL);
    assign fifo.almost_empty = (count_q == CNT_ONE);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wr_accept = fifo.wr_en && !full_flag;
        rd_accept = fifo.rd_en && !empty_flag;

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        // Simultaneous accepted write and read leaves the count unchanged.
        unique case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        wr_ack_d = wr_accept;
        wr_err_d = fifo.wr_en && !wr_accept;
        rd_ack_d = rd_accept;
        rd_err_d = fifo.rd_en && !rd_accept;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wr_ack_q <= wr_ack_d;
            wr_err_q <= wr_err_d;
            rd_ack_q <= rd_ack_d;
            rd_err_q <= rd_err_d;
        end
    end

    assign fifo.wr_ack = wr_ack_q;
    assign fifo.wr_err = wr_err_q;
    assign fifo.rd_ack = rd_ack_q;
    assign fifo.rd_err = rd_err_q;

    // ------------------------------------------------------------------
    // Storage. Requests are masked during clear so a reset edge never
    // writes the array or moves the read register.
    // ------------------------------------------------------------------
    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .srst  (clear),
        .we    (wr_accept && !clear),
        .waddr (wr_ptr_q),
        .wdata (fifo.din),
        .re    (rd_accept && !clear),
        .raddr (rd_ptr_q),
        .rdata (fifo.dout)
    );

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// ----------------------------------------------------------------------------
// tb_sync_fifo
// Directed self-checking bench for sync_fifo (DATA_WIDTH=8, DEPTH=16).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. they show the result of the edge just taken.
// Flag vector order used in checks: {full, almost_full, almost_empty, empty}.
// ----------------------------------------------------------------------------
module tb_sync_fifo;
    import sync_fifo_pkg::*;

    logic clk = 1'b0;
    logic clear;

    int checks   = 0;
    int failures = 0;

    sync_fifo_if #(.DATA_WIDTH(DEF_DATA_WIDTH)) fifo_bus ();

    sync_fifo #(
        .DATA_WIDTH (DEF_DATA_WIDTH),
        .DEPTH      (DEF_DEPTH)
    ) dut (
        .clk   (clk),
        .clear (clear),
        .fifo  (fifo_bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] flags();
        return {fifo_bus.full, fifo_bus.almost_full, fifo_bus.almost_empty, fifo_bus.empty};
    endfunction

    function automatic logic [3:0] stat();
        return {fifo_bus.wr_ack, fifo_bus.wr_err, fifo_bus.rd_ack, fifo_bus.rd_err};
    endfunction

    // One clock of stimulus; requests drop back to idle afterwards.
    task automatic step(input logic w, input logic r, input data_t d);
        fifo_bus.wr_en = w;
        fifo_bus.rd_en = r;
        fifo_bus.din   = d;
        @(posedge clk);
        #1;
        fifo_bus.wr_en = 1'b0;
        fifo_bus.rd_en = 1'b0;
    endtask

    // Status vector order: {wr_ack, wr_err, rd_ack, rd_err}.
    task automatic test_reset();
        clear          = 1'b1;
        fifo_bus.wr_en = 1'b1;
        fifo_bus.rd_en = 1'b1;
        fifo_bus.din   = 8'h5A;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (flags() !== 4'b0001) begin
            failures++; $display("FAIL reset_flags: got %b expected %b", flags(), 4'b0001);
        end
        checks++;
        if (stat() !== 4'b0000) begin
            failures++; $display("FAIL reset_status: got %b expected %b", stat(), 4'b0000);
        end
        checks++;
        if (fifo_bus.dout !== 8'h00) begin
            failures++; $display("FAIL reset_dout: got %h expected %h", fifo_bus.dout, 8'h00);
        end
        clear          = 1'b0;
        fifo_bus.wr_en = 1'b0;
        fifo_bus.rd_en = 1'b0;
        // A read right after reset must be rejected: nothing was written.
        step(1'b0, 1'b1, 8'h00);
        checks++;
        if (stat() !== 4'b0001 || flags() !== 4'b0001) begin
            failures++; $display("FAIL reset_no_write: got stat=%b flags=%b expected stat=0001 flags=0001", stat(), flags());
        end
    endtask

    task automatic test_ordering();
        data_t vals [3] = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, vals[i]);
            checks++;
            if (stat() !== 4'b1000) begin
                failures++; $display("FAIL order_wr_ack[%0d]: got %b expected %b", i, stat(), 4'b1000);
            end
            if (i == 0) begin
                checks++;
                if (flags() !== 4'b0010) begin
                    failures++; $display("FAIL order_almost_empty: got %b expected %b", flags(), 4'b0010);
                end
            end
        end
        step(1'b0, 1'b0, 8'h00);
        checks++;
        if (stat() !== 4'b0000) begin
            failures++; $display("FAIL order_idle_status: got %b expected %b", stat(), 4'b0000);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'h00);
            checks++;
            if (stat() !== 4'b0010 || fifo_bus.dout !== vals[i]) begin
                failures++; $display("FAIL order_read[%0d]: got stat=%b dout=%h expected stat=0010 dout=%h", i, stat(), fifo_bus.dout, vals[i]);
            end
        end
        checks++;
        if (flags() !== 4'b0001) begin
            failures++; $display("FAIL order_empty: got %b expected %b", flags(), 4'b0001);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, data_t'(8'hA0 + i));
            checks++;
            if (stat() !== 4'b1000) begin
                failures++; $display("FAIL fill_wr_ack[%0d]: got %b expected %b", i, stat(), 4'b1000);
            end
            if (i == 14) begin
                checks++;
                if (flags() !== 4'b0100) begin
                    failures++; $display("FAIL fill_almost_full: got %b expected %b", flags(), 4'b0100);
                end
            end
        end
        checks++;
        if (flags() !== 4'b1000) begin
            failures++; $display("FAIL fill_full: got %b expected %b", flags(), 4'b1000);
        end
        step(1'b1, 1'b0, 8'hEE);
        checks++;
        if (stat() !== 4'b0100 || flags() !== 4'b1000) begin
            failures++; $display("FAIL overflow: got stat=%b flags=%b expected stat=0100 flags=1000", stat(), flags());
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'h00);
            checks++;
            if (stat() !== 4'b0010 || fifo_bus.dout !== data_t'(8'hA0 + i)) begin
                failures++; $display("FAIL drain[%0d]: got stat=%b dout=%h expected stat=0010 dout=%h", i, stat(), fifo_bus.dout, data_t'(8'hA0 + i));
            end
            if (i == 0) begin
                checks++;
                if (flags() !== 4'b0100) begin
                    failures++; $display("FAIL drain_almost_full: got %b expected %b", flags(), 4'b0100);
                end
            end
        end
        checks++;
        if (flags() !== 4'b0001) begin
            failures++; $display("FAIL drain_empty: got %b expected %b", flags(), 4'b0001);
        end
    endtask

    task automatic test_underflow();
        step(1'b0, 1'b1, 8'h00);
        checks++;
        if (stat() !== 4'b0001 || fifo_bus.dout !== 8'hAF) begin
            failures++; $display("FAIL underflow: got stat=%b dout=%h expected stat=0001 dout=af", stat(), fifo_bus.dout);
        end
        step(1'b1, 1'b0, 8'h5C);
        checks++;
        if (flags() !== 4'b0010) begin
            failures++; $display("FAIL single_almost_empty: got %b expected %b", flags(), 4'b0010);
        end
        step(1'b0, 1'b1, 8'h00);
        checks++;
        if (fifo_bus.dout !== 8'h5C || flags() !== 4'b0001) begin
            failures++; $display("FAIL single_read: got dout=%h flags=%b expected dout=5c flags=0001", fifo_bus.dout, flags());
        end
    endtask

    task automatic test_simultaneous();
        // Count = 5: both sides accepted, count stays 5.
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, data_t'(i));
        step(1'b1, 1'b1, 8'h06);
        checks++;
        if (stat() !== 4'b1010 || fifo_bus.dout !== 8'h01 || flags() !== 4'b0000) begin
            failures++; $display("FAIL simul_mid: got stat=%b dout=%h flags=%b expected stat=1010 dout=01 flags=0000", stat(), fifo_bus.dout, flags());
        end
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 8'h00);
            checks++;
            if (fifo_bus.dout !== data_t'(2 + k)) begin
                failures++; $display("FAIL simul_mid_drain[%0d]: got %h expected %h", k, fifo_bus.dout, data_t'(2 + k));
            end
        end
        checks++;
        if (flags() !== 4'b0001) begin
            failures++; $display("FAIL simul_mid_count: got flags=%b expected %b", flags(), 4'b0001);
        end

        // Full: read accepted, write rejected, count becomes 15.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, data_t'(8'h40 + i));
        step(1'b1, 1'b1, 8'hFF);
        checks++;
        if (stat() !== 4'b0110 || fifo_bus.dout !== 8'h40 || flags() !== 4'b0100) begin
            failures++; $display("FAIL simul_full: got stat=%b dout=%h flags=%b expected stat=0110 dout=40 flags=0100", stat(), fifo_bus.dout, flags());
        end
        for (int k = 0; k < 15; k++) begin
            step(1'b0, 1'b1, 8'h00);
            checks++;
            if (fifo_bus.dout !== data_t'(8'h41 + k)) begin
                failures++; $display("FAIL simul_full_drain[%0d]: got %h expected %h", k, fifo_bus.dout, data_t'(8'h41 + k));
            end
        end
        checks++;
        if (flags() !== 4'b0001) begin
            failures++; $display("FAIL simul_full_count: got flags=%b expected %b", flags(), 4'b0001);
        end

        // Empty: write accepted, read rejected, count becomes 1.
        step(1'b1, 1'b1, 8'h77);
        checks++;
        if (stat() !== 4'b1001 || fifo_bus.dout !== 8'h4F || flags() !== 4'b0010) begin
            failures++; $display("FAIL simul_empty: got stat=%b dout=%h flags=%b expected stat=1001 dout=4f flags=0010", stat(), fifo_bus.dout, flags());
        end
        step(1'b0, 1'b1, 8'h00);
        checks++;
        if (fifo_bus.dout !== 8'h77 || flags() !== 4'b0001) begin
            failures++; $display("FAIL simul_empty_read: got dout=%h flags=%b expected dout=77 flags=0001", fifo_bus.dout, flags());
        end
    endtask

    task automatic test_wrap();
        data_t sb [$];
        data_t exp_d;
        // Keep two words in flight so each read returns an older entry.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, data_t'(8'hC0 + i));
            sb.push_back(data_t'(8'hC0 + i));
        end
        for (int n = 0; n < 40; n++) begin
            step(1'b1, 1'b0, data_t'(n));
            sb.push_back(data_t'(n));
            step(1'b0, 1'b1, 8'h00);
            exp_d = sb.pop_front();
            checks++;
            if (stat() !== 4'b0010 || fifo_bus.dout !== exp_d) begin
                failures++; $display("FAIL wrap[%0d]: got stat=%b dout=%h expected stat=0010 dout=%h", n, stat(), fifo_bus.dout, exp_d);
            end
        end
        // Clear mid-stream with requests active: reset wins.
        clear = 1'b1;
        step(1'b1, 1'b1, 8'hEE);
        clear = 1'b0;
        checks++;
        if (flags() !== 4'b0001 || stat() !== 4'b0000 || fifo_bus.dout !== 8'h00) begin
            failures++; $display("FAIL midstream_clear: got flags=%b stat=%b dout=%h expected flags=0001 stat=0000 dout=00", flags(), stat(), fifo_bus.dout);
        end
        step(1'b0, 1'b1, 8'h00);
        checks++;
        if (stat() !== 4'b0001 || fifo_bus.dout !== 8'h00) begin
            failures++; $display("FAIL post_clear_read: got stat=%b dout=%h expected stat=0001 dout=00", stat(), fifo_bus.dout);
        end
    endtask

    initial begin
        clear          = 1'b1;
        fifo_bus.wr_en = 1'b0;
        fifo_bus.rd_en = 1'b0;
        fifo_bus.din   = '0;
        test_reset();
        test_ordering();
        test_fill_overflow();
        test_underflow();
        test_simultaneous();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sync_fifo
